// File: rtl/wb_arbiter_rr.sv
// N-master to 1-slave Wishbone B3 arbiter: round-robin grant held for the whole cycle,
// with a per-access watchdog that turns a stalled slave into a bus error.
module wb_arbiter_rr #(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255,
  parameter int TW          = 8
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [NUM_MASTERS*AW-1:0]     wbm_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]     wbm_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0]   wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]        wbm_we_i,
  input  logic [NUM_MASTERS-1:0]        wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]        wbm_stb_i,
  input  logic [NUM_MASTERS*3-1:0]      wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]      wbm_bte_i,
  output logic [NUM_MASTERS*DW-1:0]     wbm_dat_o,
  output logic [NUM_MASTERS-1:0]        wbm_ack_o,
  output logic [NUM_MASTERS-1:0]        wbm_err_o,
  output logic [NUM_MASTERS-1:0]        wbm_rty_o,
  output logic [AW-1:0]                 wbs_adr_o,
  output logic [DW-1:0]                 wbs_dat_o,
  output logic [DW/8-1:0]               wbs_sel_o,
  output logic                          wbs_we_o,
  output logic                          wbs_cyc_o,
  output logic                          wbs_stb_o,
  output logic [2:0]                    wbs_cti_o,
  output logic [1:0]                    wbs_bte_o,
  input  logic [DW-1:0]                 wbs_dat_i,
  input  logic                          wbs_ack_i,
  input  logic                          wbs_err_i,
  input  logic                          wbs_rty_i,
  output logic [NUM_MASTERS-1:0]        grant_o,
  output logic                          timeout_o
);

  localparam int SW = DW / 8;
  localparam int LW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [LW-1:0]          last_q, last_d;
  logic [TW-1:0]          wd_q, wd_d;

  logic          g_cyc, g_stb, g_we;
  logic [AW-1:0] g_adr;
  logic [DW-1:0] g_dat;
  logic [SW-1:0] g_sel;
  logic [2:0]    g_cti;
  logic [1:0]    g_bte;
  logic          resp, abort, found;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      grant_q <= '0;
      last_q  <= LW'(NUM_MASTERS - 1);
      wd_q    <= '0;
    end else begin
      grant_q <= grant_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

  // Granted master's request, all zero while idle.
  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_we  = 1'b0;
    g_adr = '0;
    g_dat = '0;
    g_sel = '0;
    g_cti = '0;
    g_bte = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        g_cyc = wbm_cyc_i[i];
        g_stb = wbm_stb_i[i];
        g_we  = wbm_we_i[i];
        g_adr = wbm_adr_i[i*AW +: AW];
        g_dat = wbm_dat_i[i*DW +: DW];
        g_sel = wbm_sel_i[i*SW +: SW];
        g_cti = wbm_cti_i[i*3 +: 3];
        g_bte = wbm_bte_i[i*2 +: 2];
      end
    end
  end

  assign resp  = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign abort = (TIMEOUT != 0) && g_cyc && g_stb && !resp && (wd_q == TW'(TIMEOUT));

  // Round-robin: first requester above last, else lowest requester (wrap).
  always_comb begin
    grant_d = grant_q;
    last_d  = last_q;
    found   = 1'b0;
    if (grant_q == '0 || !g_cyc) begin
      grant_d = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (!found && wbm_cyc_i[i] && (i > int'(last_q))) begin
          found      = 1'b1;
          grant_d[i] = 1'b1;
          last_d     = LW'(i);
        end
      end
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (!found && wbm_cyc_i[i]) begin
          found      = 1'b1;
          grant_d[i] = 1'b1;
          last_d     = LW'(i);
        end
      end
    end
  end

  always_comb begin
    if ((TIMEOUT == 0) || (grant_d != grant_q) || abort || resp || !(g_cyc && g_stb))
      wd_d = '0;
    else
      wd_d = wd_q + TW'(1);
  end

  always_comb begin
    wbs_adr_o = g_adr;
    wbs_dat_o = g_dat;
    wbs_sel_o = g_sel;
    wbs_we_o  = g_we;
    wbs_cti_o = g_cti;
    wbs_bte_o = g_bte;
    wbs_cyc_o = g_cyc & ~abort;
    wbs_stb_o = g_stb & ~abort;
    wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};
    wbm_ack_o = grant_q & {NUM_MASTERS{wbs_ack_i}};
    wbm_rty_o = grant_q & {NUM_MASTERS{wbs_rty_i}};
    wbm_err_o = grant_q & {NUM_MASTERS{wbs_err_i | abort}};
    grant_o   = grant_q;
    timeout_o = abort;
  end

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Bench for wb_arbiter_rr: directed scenarios plus randomized traffic, checked every cycle
// against an index-based reference model for a TIMEOUT=5 and a TIMEOUT=0 instance.
module tb_wb_arbiter_rr;

  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NM*AW-1:0] adr = '0;
  logic [NM*DW-1:0] dat = '0;
  logic [NM*SW-1:0] sel = '0;
  logic [NM-1:0]    we = '0, cyc = '0, stb = '0;
  logic [NM*3-1:0]  cti = '0;
  logic [NM*2-1:0]  bte = '0;
  logic [DW-1:0]    sdat = '0;
  logic             sack = 1'b0, serr = 1'b0, srty = 1'b0;

  logic [NM*DW-1:0] mdat_a, mdat_b;
  logic [NM-1:0]    ack_a, err_a, rty_a, gnt_a, ack_b, err_b, rty_b, gnt_b;
  logic [AW-1:0]    sadr_a, sadr_b;
  logic [DW-1:0]    sdo_a, sdo_b;
  logic [SW-1:0]    ssel_a, ssel_b;
  logic             swe_a, scyc_a, sstb_a, to_a, swe_b, scyc_b, sstb_b, to_b;
  logic [2:0]       scti_a, scti_b;
  logic [1:0]       sbte_a, sbte_b;

  wb_arbiter_rr #(.NUM_MASTERS(NM), .AW(AW), .DW(DW), .TIMEOUT(TO), .TW(8)) dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_adr_i(adr), .wbm_dat_i(dat), .wbm_sel_i(sel), .wbm_we_i(we),
    .wbm_cyc_i(cyc), .wbm_stb_i(stb), .wbm_cti_i(cti), .wbm_bte_i(bte),
    .wbm_dat_o(mdat_a), .wbm_ack_o(ack_a), .wbm_err_o(err_a), .wbm_rty_o(rty_a),
    .wbs_adr_o(sadr_a), .wbs_dat_o(sdo_a), .wbs_sel_o(ssel_a), .wbs_we_o(swe_a),
    .wbs_cyc_o(scyc_a), .wbs_stb_o(sstb_a), .wbs_cti_o(scti_a), .wbs_bte_o(sbte_a),
    .wbs_dat_i(sdat), .wbs_ack_i(sack), .wbs_err_i(serr), .wbs_rty_i(srty),
    .grant_o(gnt_a), .timeout_o(to_a));

  wb_arbiter_rr #(.NUM_MASTERS(NM), .AW(AW), .DW(DW), .TIMEOUT(0), .TW(8)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_adr_i(adr), .wbm_dat_i(dat), .wbm_sel_i(sel), .wbm_we_i(we),
    .wbm_cyc_i(cyc), .wbm_stb_i(stb), .wbm_cti_i(cti), .wbm_bte_i(bte),
    .wbm_dat_o(mdat_b), .wbm_ack_o(ack_b), .wbm_err_o(err_b), .wbm_rty_o(rty_b),
    .wbs_adr_o(sadr_b), .wbs_dat_o(sdo_b), .wbs_sel_o(ssel_b), .wbs_we_o(swe_b),
    .wbs_cyc_o(scyc_b), .wbs_stb_o(sstb_b), .wbs_cti_o(scti_b), .wbs_bte_o(sbte_b),
    .wbs_dat_i(sdat), .wbs_ack_i(sack), .wbs_err_i(serr), .wbs_rty_i(srty),
    .grant_o(gnt_b), .timeout_o(to_b));

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Reference model: granted master index (-1 = idle), last served, stall-cycle count.
  int m_g = -1;
  int m_last = NM - 1;
  int m_wd = 0;

  function automatic bit m_abort();
    if (m_g < 0) return 1'b0;
    return cyc[m_g] && stb[m_g] && !(sack || serr || srty) && (m_wd == TO);
  endfunction

  always @(posedge clk) begin
    int ng;
    int nl;
    bit ab;
    ab = m_abort();
    ng = m_g;
    nl = m_last;
    if (m_g < 0 || !cyc[m_g]) begin
      ng = -1;
      for (int k = 1; k <= NM; k++)
        if (ng < 0 && cyc[(m_last + k) % NM]) ng = (m_last + k) % NM;
      if (ng >= 0) nl = ng;
    end
    if (rst) begin
      m_g    <= -1;
      m_last <= NM - 1;
      m_wd   <= 0;
    end else begin
      m_g    <= ng;
      m_last <= nl;
      if (ng != m_g || ab || sack || serr || srty || ng < 0 || !(cyc[ng] && stb[ng]))
        m_wd <= 0;
      else
        m_wd <= m_wd + 1;
    end
  end

  task automatic cmp(input string nm, input bit ab, input logic [NM-1:0] g_o, ack_o, err_o, rty_o,
                     input logic scyc, sstb, swe, to_o, input logic [AW-1:0] sadr,
                     input logic [DW-1:0] sdo, input logic [SW-1:0] ssel, input logic [2:0] scti,
                     input logic [1:0] sbte, input logic [NM*DW-1:0] mdat);
    logic [NM-1:0] eg, eack, eerr, erty;
    logic ecyc, estb, ewe;
    logic [4*NM+3:0] got_c, exp_c;
    logic [AW+DW+SW+4:0] got_r, exp_r;
    eg = '0; eack = '0; eerr = '0; erty = '0;
    ecyc = 1'b0; estb = 1'b0; ewe = 1'b0;
    exp_r = '0;
    if (m_g >= 0) begin
      eg[m_g]   = 1'b1;
      eack[m_g] = sack;
      erty[m_g] = srty;
      eerr[m_g] = serr | ab;
      ecyc = cyc[m_g] & ~ab;
      estb = stb[m_g] & ~ab;
      ewe  = we[m_g];
      exp_r = {adr[m_g*AW +: AW], dat[m_g*DW +: DW], sel[m_g*SW +: SW], cti[m_g*3 +: 3], bte[m_g*2 +: 2]};
    end
    got_c = {g_o, ack_o, err_o, rty_o, scyc, sstb, swe, to_o};
    exp_c = {eg, eack, eerr, erty, ecyc, estb, ewe, ab};
    got_r = {sadr, sdo, ssel, scti, sbte};
    checks++;
    if (got_c !== exp_c || (m_g >= 0 && got_r !== exp_r) || mdat !== {NM{sdat}}) begin
      errors++;
      $display("FAIL %s t=%0t ctl got=%h exp=%h route got=%h exp=%h",
               nm, $time, got_c, exp_c, got_r, exp_r);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("cycle_to5", m_abort(), gnt_a, ack_a, err_a, rty_a, scyc_a, sstb_a, swe_a, to_a,
          sadr_a, sdo_a, ssel_a, scti_a, sbte_a, mdat_a);
      cmp("cycle_to0", 1'b0, gnt_b, ack_b, err_b, rty_b, scyc_b, sstb_b, swe_b, to_b,
          sadr_b, sdo_b, ssel_b, scti_b, sbte_b, mdat_b);
    end
  end

  task automatic lit(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc = '0; stb = '0; cti = '0;
    sack = 1'b0; serr = 1'b0; srty = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic int oh_idx(input logic [NM-1:0] v);
    for (int i = 0; i < NM; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    int g;
    int prev;
    int stall;

    // Reset state, simultaneous request and zero-gap handover
    do_reset();
    @(negedge clk);
    lit("reset_grant", gnt_a, 0);
    lit("reset_cyc", {scyc_a, sstb_a, to_a}, 0);
    tick();
    cyc = 4'b0011; stb = 4'b0011;
    tick();
    @(negedge clk);
    lit("first_grant", gnt_a, 4'b0001);
    tick();
    cyc[0] = 1'b0; stb[0] = 1'b0;
    tick();
    @(negedge clk);
    lit("handover_grant", gnt_a, 4'b0010);
    lit("handover_no_gap", scyc_a, 1'b1);

    // Fairness with every master requesting single accesses
    do_reset();
    cyc = 4'b1111; stb = 4'b1111;
    tick();
    prev = -1;
    for (int k = 0; k < 8; k++) begin
      g = oh_idx(gnt_a);
      lit("rr_order", g, k % 4);
      lit("rr_not_repeat", (g == prev), 0);
      prev = g;
      sack = 1'b1;
      tick();
      if (g >= 0) begin cyc[g] = 1'b0; stb[g] = 1'b0; end
      sack = 1'b0;
      tick();
      if (g >= 0) begin cyc[g] = 1'b1; stb[g] = 1'b1; end
    end

    // 8-beat burst from master 1 is not split by master 0
    do_reset();
    cyc[1] = 1'b1; stb[1] = 1'b1; cti[5:3] = 3'b010;
    tick();
    cyc[0] = 1'b1; stb[0] = 1'b1;
    for (int b = 0; b < 8; b++) begin
      cti[5:3] = (b == 7) ? 3'b111 : 3'b010;
      sack = 1'b1;
      @(negedge clk);
      lit("burst_grant", gnt_a, 4'b0010);
      lit("burst_ack", ack_a, 4'b0010);
      lit("burst_cti", scti_a, (b == 7) ? 3'b111 : 3'b010);
      tick();
    end
    cyc[1] = 1'b0; stb[1] = 1'b0; sack = 1'b0;
    tick();
    lit("after_burst_grant", gnt_a, 4'b0001);

    // Watchdog: err on exactly the 6th stalled strobe cycle
    do_reset();
    cyc[2] = 1'b1; stb[2] = 1'b1;
    tick();
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      lit("wd_err", err_a, (c == 6) ? 4'b0100 : 4'b0000);
      lit("wd_pulse", to_a, (c == 6));
      lit("wd_stb", sstb_a, (c != 6));
      lit("wd_disabled_err", {err_b, to_b}, 0);
      tick();
    end
    repeat (10) tick();

    // Reset mid-burst
    do_reset();
    cyc[1] = 1'b1; stb[1] = 1'b1; cti[5:3] = 3'b010; sack = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    cyc[0] = 1'b1; stb[0] = 1'b1;
    tick();
    @(negedge clk);
    lit("rst_mid_cyc", scyc_a, 1'b0);
    lit("rst_mid_grant", gnt_a, 0);
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    lit("post_rst_grant", gnt_a, 4'b0001);

    // Retry goes only to master 2
    do_reset();
    cyc = 4'b1100; stb = 4'b1100;
    tick();
    srty = 1'b1;
    @(negedge clk);
    lit("rty_vec", rty_a, 4'b0100);
    lit("rty_others", {ack_a, err_a}, 0);
    tick();
    srty = 1'b0;

    // Randomized traffic
    do_reset();
    stall = 0;
    for (int n = 0; n < 4000; n++) begin
      tick();
      for (int m = 0; m < NM; m++) begin
        if (cyc[m]) cyc[m] = ($urandom_range(0, 9) != 0);
        else        cyc[m] = ($urandom_range(0, 5) == 0);
        stb[m] = cyc[m] && ($urandom_range(0, 3) != 0);
        we[m]  = $urandom_range(0, 1);
      end
      for (int w = 0; w < NM; w++) begin
        adr[w*AW +: AW] = $urandom;
        dat[w*DW +: DW] = $urandom;
      end
      sel = $urandom;
      cti = $urandom;
      bte = $urandom;
      sdat = $urandom;
      if (stall == 0 && $urandom_range(0, 150) == 0) stall = 25;
      if (stall > 0) begin
        stall--;
        sack = 1'b0; serr = 1'b0; srty = 1'b0;
      end else begin
        sack = ($urandom_range(0, 2) == 0);
        serr = ($urandom_range(0, 12) == 0);
        srty = ($urandom_range(0, 16) == 0);
      end
      rst = ($urandom_range(0, 699) == 0);
    end
    rst = 1'b0;
    tick();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
